// File: rtl/poly_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// poly_add_ctrl_pkg : shared constants, defaults and FSM encoding for poly_add
// Revision: 1.0
// ============================================================================
package poly_add_ctrl_pkg;

    localparam int unsigned NEWHOPE_Q     = 12289;
    localparam int unsigned NEWHOPE_2Q    = 24578;
    localparam int unsigned DEFAULT_N     = 1024;
    localparam int unsigned DEFAULT_LOG_N = 10;
    localparam int unsigned COEFF_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    // Operands are both < q, so their sum is < 2q and one conditional subtract suffices.
    function automatic logic [COEFF_W-1:0] mod_q_reduce(input logic [COEFF_W-1:0] s);
        return (s >= COEFF_W'(NEWHOPE_Q)) ? (s - COEFF_W'(NEWHOPE_Q)) : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/poly_add_coeff.sv
`default_nettype none
// ============================================================================
// poly_add_coeff : two-stage (a + b) mod q coefficient adder with valid flag
// Revision: 1.0
// ============================================================================
module poly_add_coeff
    import poly_add_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               start,
    input  logic [COEFF_W-1:0] dia,
    input  logic [COEFF_W-1:0] dib,
    output logic [COEFF_W-1:0] dout,
    output logic               done
);

    logic [COEFF_W-1:0] sum_q, sum_d;
    logic [COEFF_W-1:0] dout_q, dout_d;
    logic               start_q, start_d;
    logic               done_q, done_d;

    always_comb begin
        sum_d   = dia + dib;
        start_d = start;
        dout_d  = mod_q_reduce(sum_q);
        done_d  = start_q;
    end

    // Pure datapath: no reset, the controller owns the write strobe.
    always_ff @(posedge clk) begin
        sum_q   <= sum_d;
        start_q <= start_d;
        dout_q  <= dout_d;
        done_q  <= done_d;
    end

    assign dout = dout_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: rtl/poly_add_ctrl.sv
`default_nettype none
// ============================================================================
// poly_add_ctrl : streams A[i]+B[i] mod q from two source RAMs to a result RAM
// Revision: 1.0
// ============================================================================
module poly_add_ctrl
    import poly_add_ctrl_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int LOG_N = DEFAULT_LOG_N
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [LOG_N-1:0]   rd_addr,
    input  logic [COEFF_W-1:0] dia,
    input  logic [COEFF_W-1:0] dib,
    output logic               wr_en,
    output logic [LOG_N-1:0]   wr_addr,
    output logic [COEFF_W-1:0] wr_data
);

    // One RAM read cycle plus the two adder stages.
    localparam int DLY = 3;
    localparam logic [LOG_N-1:0] LAST_ADDR = LOG_N'(N - 1);

    state_t             state_q, state_d;
    logic [LOG_N-1:0]   addr_q, addr_d;
    logic [DLY-1:0]     en_dly_q, en_dly_d;
    logic [LOG_N-1:0]   addr_dly_q [DLY];
    logic [LOG_N-1:0]   addr_dly_d [DLY];
    logic [COEFF_W-1:0] coeff_dout;
    logic               coeff_done;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_READ;
            end
            ST_READ: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                    addr_d  = '0;
                end else begin
                    addr_d  = addr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (wr_en && (wr_addr == LAST_ADDR)) state_d = ST_FIN;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_en   = (state_q == ST_READ);
        rd_addr = addr_q;
        busy    = (state_q == ST_READ) || (state_q == ST_DRAIN);
        done    = (state_q == ST_FIN);
    end

    always_comb begin
        en_dly_d      = {en_dly_q[DLY-2:0], rd_en};
        addr_dly_d[0] = addr_q;
        for (int k = 1; k < DLY; k++) begin
            addr_dly_d[k] = addr_dly_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            en_dly_q   <= '0;
            addr_dly_q <= '{default: '0};
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            en_dly_q   <= en_dly_d;
            addr_dly_q <= addr_dly_d;
        end
    end

    // Stage 0 of the enable delay marks the cycle the RAM data is valid.
    poly_add_coeff u_coeff (
        .clk   (clk),
        .start (en_dly_q[0]),
        .dia   (dia),
        .dib   (dib),
        .dout  (coeff_dout),
        .done  (coeff_done)
    );

    assign wr_en   = en_dly_q[DLY-1];
    assign wr_addr = addr_dly_q[DLY-1];
    assign wr_data = coeff_dout;

    // The adder's unreset valid flag only cross-checks the reset-safe strobe.
    always @(posedge clk) begin
        if (!rst && wr_en) assert (coeff_done);
    end

endmodule
`default_nettype wire

// File: tb/tb_poly_add_ctrl.sv
`default_nettype none
// ============================================================================
// tb_poly_add_ctrl : randomized self-checking bench for poly_add_ctrl (N=8, N=1024)
// Revision: 1.0
// ============================================================================
module tb_poly_add_ctrl;

    localparam int N8 = 8;
    localparam int L8 = 3;
    localparam int NK = 1024;
    localparam int LK = 10;
    localparam int Q  = 12289;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start8 = 1'b0;
    logic startk = 1'b0;

    logic          busy8, done8, rd_en8, wr_en8;
    logic [L8-1:0] rd_addr8, wr_addr8;
    logic [15:0]   wr_data8;
    logic [15:0]   dia8 = '0, dib8 = '0;

    logic          busyk, donek, rd_enk, wr_enk;
    logic [LK-1:0] rd_addrk, wr_addrk;
    logic [15:0]   wr_datak;
    logic [15:0]   diak = '0, dibk = '0;

    int a_mem [NK];
    int b_mem [NK];

    int cyc    = 0;
    int st8    = -1;
    int stk    = -1;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    poly_add_ctrl #(.N(N8), .LOG_N(L8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8),
        .rd_en(rd_en8), .rd_addr(rd_addr8), .dia(dia8), .dib(dib8),
        .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_data(wr_data8)
    );

    poly_add_ctrl #(.N(NK), .LOG_N(LK)) dutk (
        .clk(clk), .rst(rst), .start(startk), .busy(busyk), .done(donek),
        .rd_en(rd_enk), .rd_addr(rd_addrk), .dia(diak), .dib(dibk),
        .wr_en(wr_enk), .wr_addr(wr_addrk), .wr_data(wr_datak)
    );

    // Synchronous-read source RAMs shared by both instances.
    always @(posedge clk) begin
        if (rd_en8) begin
            dia8 <= 16'(a_mem[int'(rd_addr8)]);
            dib8 <= 16'(b_mem[int'(rd_addr8)]);
        end
        if (rd_enk) begin
            diak <= 16'(a_mem[int'(rd_addrk)]);
            dibk <= 16'(b_mem[int'(rd_addrk)]);
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected behaviour from the pass timeline: cycle of accepted start = rel 0.
    task automatic model_chk(input string nm, input int n, input int st,
                             input logic busy, input logic done, input logic rd_en,
                             input int rd_addr, input logic wr_en, input int wr_addr,
                             input int wr_data);
        int rel;
        bit act_rd, act_wr;
        rel    = (st < 0) ? -1 : (cyc - st);
        act_rd = (rel >= 1) && (rel <= n);
        act_wr = (rel >= 4) && (rel <= n + 3);
        check({nm, ".busy"},    busy,    (rel >= 1) && (rel <= n + 3));
        check({nm, ".done"},    done,    rel == n + 4);
        check({nm, ".rd_en"},   rd_en,   act_rd);
        check({nm, ".rd_addr"}, rd_addr, act_rd ? rel - 1 : 0);
        check({nm, ".wr_en"},   wr_en,   act_wr);
        check({nm, ".wr_addr"}, wr_addr, act_wr ? rel - 4 : 0);
        if (act_wr)
            check({nm, ".wr_data"}, wr_data, (a_mem[rel-4] + b_mem[rel-4]) % Q);
    endtask

    task automatic cycle(input logic s8, input logic sk);
        @(negedge clk);
        cyc++;
        model_chk("n8", N8, st8, busy8, done8, rd_en8, int'(rd_addr8),
                  wr_en8, int'(wr_addr8), int'(wr_data8));
        model_chk("n1k", NK, stk, busyk, donek, rd_enk, int'(rd_addrk),
                  wr_enk, int'(wr_addrk), int'(wr_datak));
        start8 = s8;
        startk = sk;
        if (s8 && !rst && (st8 < 0 || cyc - st8 >= N8 + 5)) st8 = cyc;
        if (sk && !rst && (stk < 0 || cyc - stk >= NK + 5)) stk = cyc;
    endtask

    task automatic run(input int k);
        repeat (k) cycle(1'b0, 1'b0);
    endtask

    // mode 0: zeros, 1: q-1/q-1, 2: q-1/1, 3: i/5, otherwise random < q
    task automatic load(input int mode);
        for (int i = 0; i < NK; i++) begin
            case (mode)
                0: begin a_mem[i] = 0;     b_mem[i] = 0;     end
                1: begin a_mem[i] = Q - 1; b_mem[i] = Q - 1; end
                2: begin a_mem[i] = Q - 1; b_mem[i] = 1;     end
                3: begin a_mem[i] = i;     b_mem[i] = 5;     end
                default: begin
                    a_mem[i] = int'($urandom_range(Q - 1, 0));
                    b_mem[i] = int'($urandom_range(Q - 1, 0));
                end
            endcase
        end
    endtask

    initial begin
        load(0);
        run(3);
        rst = 1'b0;
        run(2);

        for (int m = 0; m < 4; m++) begin
            load(m);
            cycle(1'b1, 1'b0);
            run(N8 + 6);
        end

        // Starts during busy and coincident with done are ignored; rel 13 starts anew.
        load(4);
        cycle(1'b1, 1'b0);
        for (int r = 1; r <= 13; r++) cycle(r == 3 || r == 12 || r == 13, 1'b0);
        run(N8 + 6);

        // Asynchronous reset in the middle of a pass.
        load(4);
        cycle(1'b1, 1'b0);
        run(6);
        #1 rst = 1'b1;
        st8 = -1;
        #1;
        check("async.busy",    busy8,           0);
        check("async.done",    done8,           0);
        check("async.rd_en",   rd_en8,          0);
        check("async.wr_en",   wr_en8,          0);
        check("async.rd_addr", int'(rd_addr8),  0);
        check("async.wr_addr", int'(wr_addr8),  0);
        run(2);
        rst = 1'b0;
        run(N8 + 6);
        load(4);
        cycle(1'b1, 1'b0);
        run(N8 + 6);

        load(4);
        cycle(1'b0, 1'b1);
        run(NK + 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
